cnn_mul_rr_sched: RTL

- Time-shares one signed 14x7 -> 21-bit multiplier among NUM_REQ requesters, such as the PE lanes of a conv layer.
- Arbitration is round-robin, with valid/ready handshakes on both the request side and the response side.
- Each result is tagged with the ID of the requester that issued it.
- Sits between the layer's loop controllers and the single shared DSP48-mapped multiply.

---
 rtl/cnn_mul_pkg.sv | 29 ++
 rtl/cnn_mul_core_14s_7s.sv | 18 +
 rtl/cnn_mul_rr_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cnn_mul_pkg.sv
// Shared types and widths for the time-shared signed 14x7 multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_mul_pkg;

    localparam int A_W = 14;
    localparam int B_W = 7;
    localparam int P_W = 21;

    typedef logic signed [A_W-1:0] mul_a_t;
    typedef logic signed [B_W-1:0] mul_b_t;
    typedef logic signed [P_W-1:0] mul_p_t;

    // Stage-1 payload: granted operands plus the issuing requester.
    typedef struct packed {
        logic   vld;
        mul_a_t a;
        mul_b_t b;
        logic [7:0] id;
    } s1_t;

    // Stage-2 payload: full-precision product plus the issuing requester.
    typedef struct packed {
        logic   vld;
        mul_p_t p;
        logic [7:0] id;
    } s2_t;

endpackage

// File: rtl/cnn_mul_core_14s_7s.sv
// Purely combinational signed 14x7 -> 21-bit multiply, shaped for a single DSP48.
// Latency: 0 cycles (the surrounding pipeline provides the input/output registers).
// Backpressure: none; the caller holds its registers when stalled.
// Ports: a (signed 14b), b (signed 7b) in; p (signed 21b, exact product) out.
module cnn_mul_core_14s_7s
    import cnn_mul_pkg::*;
(
    input  mul_a_t a,
    input  mul_b_t b,
    output mul_p_t p
);

    // Both operands are sign-extended to the product width before the
    // multiply; the exact result always fits in 21 bits, so truncating the
    // self-determined product to P_W bits loses nothing.
    assign p = mul_p_t'(a) * mul_p_t'(b);

endmodule

// File: rtl/cnn_mul_rr_sched.sv
// Round-robin scheduler sharing one signed 14x7 multiplier among NUM_REQ requesters.
// Latency: 2 cycles from request handshake to resp_valid; one product per cycle sustained.
// Backpressure: resp_valid & ~resp_ready freezes both stages and drops every req_ready.
// Ports:
//   ap_clk, ap_rst_n              clock, async active-low reset
//   req_valid/req_ready [NUM_REQ] per-requester handshake; req_a/req_b packed operands
//   resp_valid/resp_ready         product handshake; resp_id tags the issuer, resp_p product
//   busy                          any pipeline stage holds valid data
module cnn_mul_rr_sched
    import cnn_mul_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [P_W-1:0]         resp_p,
    output logic                   busy
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic              s1_vld;
    mul_a_t            s1_a;
    mul_b_t            s1_b;
    logic [ID_W-1:0]   s1_id;

    logic              s2_vld;
    mul_p_t            s2_p;
    logic [ID_W-1:0]   s2_id;

    logic [ID_W-1:0]   rr_ptr;

    // ------------------------------------------------------------------
    // Stall: the only hold condition is an unconsumed output.
    // ------------------------------------------------------------------
    logic stall;
    assign stall = s2_vld & ~resp_ready;

    // ------------------------------------------------------------------
    // Round-robin grant: first valid requester at or above the pointer,
    // wrapping modulo NUM_REQ.
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;

    always_comb begin
        grant   = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_any && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                gnt_any = 1'b1;
                grant[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
                gnt_id  = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready = stall ? '0 : grant;

    // A grant only exists when its requester is valid, so a handshake
    // happens exactly when something is granted and we are not stalled.
    logic hs;
    assign hs = gnt_any & ~stall;

    // Operand mux for the granted requester.
    mul_a_t gnt_a;
    mul_b_t gnt_b;
    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_a = mul_a_t'(req_a[i*A_W +: A_W]);
                gnt_b = mul_b_t'(req_b[i*B_W +: B_W]);
            end
        end
    end

    // Next pointer value after a handshake, with explicit wrap so that
    // non-power-of-two NUM_REQ also returns to 0.
    logic [ID_W-1:0] ptr_nxt;
    always_comb begin
        if (gnt_id == ID_W'(NUM_REQ - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = gnt_id + ID_W'(1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: granted operands and ID. A cycle with no handshake while
    // not stalled loads a bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_vld <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_id  <= '0;
        end else if (!stall) begin
            s1_vld <= hs;
            if (hs) begin
                s1_a  <= gnt_a;
                s1_b  <= gnt_b;
                s1_id <= gnt_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared multiplier between S1 and S2.
    // ------------------------------------------------------------------
    mul_p_t mul_p;

    cnn_mul_core_14s_7s u_core (
        .a (s1_a),
        .b (s1_b),
        .p (mul_p)
    );

    // ------------------------------------------------------------------
    // Stage 2: product and ID. When the output is consumed in the same
    // cycle, S1 moves straight in, so no bubble is inserted.
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s2_vld <= 1'b0;
            s2_p   <= '0;
            s2_id  <= '0;
        end else if (!stall) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_p  <= mul_p;
                s2_id <= s1_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs straight from S2.
    // ------------------------------------------------------------------
    assign resp_valid = s2_vld;
    assign resp_id    = s2_id;
    assign resp_p     = s2_p;
    assign busy       = s1_vld | s2_vld;

endmodule
